// File: rtl/alu_pkg.sv
// Shared ALU function codes, shift op encodings and sequencer states.
// Used by shift_sequencer (optional flags: SHIFT_FLAGS_EN).
package alu_pkg;

  localparam logic [4:0] FS_PASS_T = 5'h01;
  localparam logic [4:0] FS_SLL    = 5'h0C;
  localparam logic [4:0] FS_SRL    = 5'h0D;
  localparam logic [4:0] FS_SRA    = 5'h0E;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [4:0] op_fs(input logic [1:0] op);
    logic [4:0] fs;
    case (op)
      OP_SLL:  fs = FS_SLL;
      OP_SRL:  fs = FS_SRL;
      OP_SRA:  fs = FS_SRA;
      default: fs = FS_PASS_T;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Iterates the ALU 1-bit shift functions to build 0..31-bit shifts.
// Optional result_n/result_z outputs when SHIFT_FLAGS_EN is defined.
module shift_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  t_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               carry_out,
  output logic               err,
`ifdef SHIFT_FLAGS_EN
  output logic               result_n,
  output logic               result_z,
`endif
  output logic [4:0]         alu_fs,
  output logic [DATA_W-1:0]  alu_s,
  output logic [DATA_W-1:0]  alu_t,
  input  logic [DATA_W-1:0]  alu_y_lo,
  input  logic               alu_c
);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_acc;
  logic [SHAMT_W-1:0]  r_cnt;
  logic [4:0]          r_fs;
  logic [DATA_W-1:0]   r_result;
  logic                r_carry_out;
  logic                r_err;

  logic                w_ready;
  logic                w_accept;
  logic                w_fast;
  logic                w_fin;
  logic                w_upd;
  logic [DATA_W-1:0]   w_res_d;

  assign w_ready  = (r_state == IDLE) || (r_state == DONE);
  assign w_accept = w_ready && start;
  assign w_fast   = (op == OP_RSVD) || (shamt == '0);
  assign w_fin    = (r_state == SHIFT) && (r_cnt == SHAMT_W'(1));
  assign w_upd    = (w_accept && w_fast) || w_fin;
  assign w_res_d  = w_fin ? alu_y_lo : t_in;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = w_fast ? DONE : SHIFT;
      SHIFT:   if (r_cnt == SHAMT_W'(1)) w_next = DONE;
      DONE: begin
        if (start) w_next = w_fast ? DONE : SHIFT;
        else       w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready  = w_ready;
    busy   = 1'b0;
    done   = 1'b0;
    alu_fs = FS_PASS_T;
    unique case (r_state)
      SHIFT: begin
        busy   = 1'b1;
        alu_fs = r_fs;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_fs        <= FS_PASS_T;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= t_in;
        r_cnt <= shamt;
        r_fs  <= op_fs(op);
      end else if (r_state == SHIFT) begin
        r_acc <= alu_y_lo;
        r_cnt <= r_cnt - SHAMT_W'(1);
      end
      // Fast path (zero shift / reserved op) reports no carry
      if (w_upd) begin
        r_result    <= w_res_d;
        r_carry_out <= w_fin ? alu_c : 1'b0;
        r_err       <= w_fin ? 1'b0 : (op == OP_RSVD);
      end
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic r_n;
  logic r_z;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n <= 1'b0;
      r_z <= 1'b0;
    end else if (w_upd) begin
      r_n <= w_res_d[DATA_W-1];
      r_z <= (w_res_d == '0);
    end
  end

  assign result_n = r_n;
  assign result_z = r_z;
`endif

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign err       = r_err;
  assign alu_s     = '0;
  assign alu_t     = r_acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 1-bit-shift ALU.
// Define SHIFT_FLAGS_EN to also check result_n/result_z.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] t_in;
  logic        ready, busy, done, carry_out, err;
  logic [31:0] result;
  logic [4:0]  alu_fs;
  logic [31:0] alu_s, alu_t, alu_y_lo;
  logic        alu_c;
`ifdef SHIFT_FLAGS_EN
  logic        result_n, result_z;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .shamt(shamt), .t_in(t_in), .ready(ready), .busy(busy),
    .done(done), .result(result), .carry_out(carry_out),
    .err(err),
`ifdef SHIFT_FLAGS_EN
    .result_n(result_n), .result_z(result_z),
`endif
    .alu_fs(alu_fs), .alu_s(alu_s), .alu_t(alu_t),
    .alu_y_lo(alu_y_lo), .alu_c(alu_c)
  );

  // Single-bit-shift ALU model
  always_comb begin
    alu_y_lo = alu_t;
    alu_c    = 1'b0;
    case (alu_fs)
      5'h0C: begin alu_y_lo = alu_t << 1; alu_c = alu_t[31]; end
      5'h0D: begin alu_y_lo = alu_t >> 1; alu_c = alu_t[0]; end
      5'h0E: begin
        alu_y_lo = {alu_t[31], alu_t[31:1]};
        alu_c    = alu_t[0];
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [4:0] s,
                     input logic [31:0] t, input bit noise,
                     input logic [4:0] efs,
                     output int lat, output int nbusy,
                     output int fsbad);
    op = o; shamt = s; t_in = t; start = 1'b1;
    lat = 0; nbusy = 0; fsbad = 0;
    do begin
      @(negedge clk);
      lat++;
      start = noise && busy && (lat % 2 == 1);
      if (start) begin
        op = 2'b00; shamt = 5'd1; t_in = $urandom;
      end
      if (busy) begin
        nbusy++;
        if (alu_fs !== efs) fsbad++;
      end
    end while (!done && lat < 100);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  sh;
    logic [31:0] t;
    logic [31:0] res;
    logic        c;
    logic        e;
    bit          noise;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat, nb, fb, dn;
    logic [4:0] efs;
    bit fast;
    tbl[0] = '{2'b00, 5'd4,  32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 0};
    tbl[1] = '{2'b01, 5'd1,  32'h8000_0001, 32'h4000_0000, 1'b1, 1'b0, 0};
    tbl[2] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    tbl[3] = '{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 0};
    tbl[4] = '{2'b11, 5'd5,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 0};
    tbl[5] = '{2'b00, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 0};
    tbl[6] = '{2'b01, 5'd8,  32'h1234_5678, 32'h0012_3456, 1'b0, 1'b0, 0};
    tbl[7] = '{2'b10, 5'd3,  32'h7FFF_FFFF, 32'h0FFF_FFFF, 1'b1, 1'b0, 0};

    reset = 1'b1; start = 1'b0; op = '0; shamt = '0; t_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_fs", 32'(alu_fs), 32'h01);
    chk("rst_alu_t", alu_t, 32'd0);
    chk("alu_s", alu_s, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      efs  = 5'h0C + 5'(tbl[i].op);
      fast = (tbl[i].op == 2'b11) || (tbl[i].sh == 0);
      run(tbl[i].op, tbl[i].sh, tbl[i].t, tbl[i].noise, efs,
          lat, nb, fb);
      chk($sformatf("v%0d_lat", i), lat, fast ? 1 : tbl[i].sh + 1);
      chk($sformatf("v%0d_busy", i), nb, fast ? 0 : 32'(tbl[i].sh));
      chk($sformatf("v%0d_fs", i), fb, 0);
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
      chk($sformatf("v%0d_res", i), result, tbl[i].res);
      chk($sformatf("v%0d_c", i), 32'(carry_out), 32'(tbl[i].c));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].e));
`ifdef SHIFT_FLAGS_EN
      chk($sformatf("v%0d_n", i), 32'(result_n), 32'(tbl[i].res[31]));
      chk($sformatf("v%0d_z", i), 32'(result_z),
          32'(tbl[i].res == 0));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done1", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_hold", i), result, tbl[i].res);
    end

    // Reset in the third SHIFT cycle of SLL by 10
    op = 2'b00; shamt = 5'd10; t_in = 32'h0000_0003; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_ready", 32'(ready), 32'd1);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_result", result, 32'd0);
    chk("mid_fs", 32'(alu_fs), 32'h01);
    chk("mid_alu_t", alu_t, 32'd0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("mid_nodone", dn, 0);

    // start and reset together
    reset = 1'b1; start = 1'b1; shamt = 5'd4;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("sr_busy", 32'(busy), 32'd0);
    chk("sr_ready", 32'(ready), 32'd1);
    @(negedge clk);
    chk("sr_idle", 32'(busy | done), 32'd0);

    // Back-to-back: second start held in the first DONE cycle
    run(2'b00, 5'd2, 32'h1, 0, 5'h0C, lat, nb, fb);
    chk("b2b_first", result, 32'h4);
    chk("b2b_done1", 32'(done), 32'd1);
    run(2'b01, 5'd4, 32'hF0, 0, 5'h0D, lat, nb, fb);
    chk("b2b_lat", lat, 5);
    chk("b2b_busy", nb, 4);
    chk("b2b_res", result, 32'h0F);
    chk("b2b_c", 32'(carry_out), 32'd0);

    // Result of zero
    run(2'b01, 5'd1, 32'h1, 0, 5'h0D, lat, nb, fb);
    chk("zero_res", result, 32'h0);
    chk("zero_c", 32'(carry_out), 32'd1);
`ifdef SHIFT_FLAGS_EN
    chk("zero_z", 32'(result_z), 32'd1);
    chk("zero_n", 32'(result_n), 32'd0);
`endif
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
